ctrl_capture_seq: RTL and testbench
===================================

# ctrl_capture_seq

Capture sequencer for the digital camera pixel array. It accepts the `init` and `exposure` user triggers and the current exposure setting from the exposure-time controller, then drives the array through erase, expose and two-row readout phases. All phases are timed in `clk` cycles; one `clk` cycle is 1 ms. It sits between the user-button debouncers and the pixel array/ADC, alongside the exposure-time controller.

## Interface
- `EX_W`, 5: exposure-time width in bits.
- `EX_MIN`, 2: minimum exposure in cycles.
- `EX_MAX`, 30: maximum exposure in cycles.
- `ERASE_CYC`, 2: erase phase length in cycles.
- `clk`  in  1  system clock, 1 ms period; one clock domain.
- `reset`  in  1  reset; asynchronous, active-low.
- `init`  in  1  erase request, level-sampled each cycle.
- `exposure`  in  1  capture request, level-sampled each cycle.
- `ex_time`  in  EX_W  exposure length in cycles, from the exposure-time controller.
- `erase`  out  1  pixel erase, active-high.
- `expose`  out  1  pixel integrate, active-high.
- `nre_1`  out  1  row-1 read enable, active-low.
- `nre_2`  out  1  row-2 read enable, active-low.
- `adc`  out  1  ADC convert strobe, active-high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse marking capture completion.

## Operation
- States:
  - IDLE
  - ERASE
  - EXPOSE
  - RD1_A and RD1_B (row 1)
  - RD2_A and RD2_B (row 2)
- Reset (`reset`=0) forces IDLE immediately. Outputs during reset: `erase`=0, `expose`=0, `nre_1`=1, `nre_2`=1, `adc`=0, `busy`=0, `done`=0. The internal counter and latched exposure clear to 0.
- Triggers are sampled only in IDLE:
  - `init`=1 → ERASE. `init` wins if `init` and `exposure` are both high.
  - `exposure`=1 with `init`=0 → EXPOSE.
- Triggers seen outside IDLE are ignored, not queued. A level still high on return to IDLE starts a new operation.
- On the EXPOSE transition, `ex_time` is latched and clamped: values below EX_MIN become EX_MIN, values above EX_MAX become EX_MAX. Changes to `ex_time` after latching have no effect on the current capture.
- ERASE: `erase`=1 for exactly ERASE_CYC cycles, then IDLE. No `done` pulse.
- EXPOSE: `expose`=1 for exactly the latched N cycles, then RD1_A.
- Readout, one cycle per state:
  - RD1_A: `nre_1`=0, `adc`=0.
  - RD1_B: `nre_1`=0, `adc`=1.
  - RD2_A: `nre_2`=0, `adc`=0.
  - RD2_B: `nre_2`=0, `adc`=1.
  - After RD2_B → IDLE.
- `done`=1 in the first IDLE cycle after RD2_B only.
- `nre_1` and `nre_2` are never low in the same cycle. At most one of `erase`, `expose`, `adc` is high in any cycle.
- Counter: an EX_W-bit down-counter, loaded on phase entry and decremented each cycle. The phase ends when the counter reaches 1. It never wraps.

## Timing
- All outputs are registered and are functions of the current state only. No combinational input-to-output paths.
- Trigger sampled high at edge k: phase outputs are high from edge k+1.
- Capture with latched N: `expose` is high for cycles k+1 … k+N. Row-1 readout occupies k+N+1 and k+N+2; row-2 readout occupies k+N+3 and k+N+4. `done` is high at k+N+5.
- Total `busy` time is N+4 cycles. Erase `busy` time is ERASE_CYC cycles.
- Earliest retrigger is at the edge where `done` is high. That edge is sampled in IDLE, so back-to-back captures have a one-cycle gap.
- Reset asserted mid-phase: outputs go to their reset values asynchronously. No `done` pulse. Operation resumes in IDLE on the first edge after release.

## Structure
- Shared package `cam_pkg`:
  - State enumeration (7 states).
  - Constants EX_MIN=2, EX_MAX=30, EX_DEFAULT=15, ERASE_CYC=2.
  - Readout row count and cycles per row.
- The exposure-time controller reuses the same EX_MIN, EX_MAX and EX_DEFAULT constants.
- One sub-module, `ctrl_phase_timer`: a loadable EX_W-bit down-counter with `load`, `load_val` and a `last` flag. It is instantiated once and shared across the ERASE and EXPOSE phases.

## Test plan
- Reset, then `exposure` pulse with `ex_time`=15 → `expose` high 15 cycles, then `nre_1` low 2 cycles (`adc` on the 2nd), `nre_2` low 2 cycles (`adc` on the 2nd), `done` at trigger+20, `busy` high 19 cycles.
- `ex_time`=0 and then `ex_time`=31 captures → `expose` lasts 2 and 30 cycles respectively.
- `init` and `exposure` both high in IDLE → `erase` high exactly 2 cycles, `expose` never high, no `done`.
- `ex_time` changed from 10 to 3 during EXPOSE, with `exposure` re-pulsed mid-capture → `expose` still 10 cycles, single `done`, no second capture.
- `reset` low at cycle 5 of a 20-cycle exposure → all outputs at reset values immediately. After release, the next `exposure` yields a full, correct capture.
- `exposure` held high continuously with `ex_time`=2 → repeated 6-cycle `busy` windows separated by one IDLE cycle carrying `done`. `nre_1` and `nre_2` never low together.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared camera constants, capture-sequencer state encoding and the exposure clamp.
package cam_pkg;

  localparam int EX_W           = 5;
  localparam int EX_MIN         = 2;
  localparam int EX_MAX         = 30;
  localparam int EX_DEFAULT     = 15;
  localparam int ERASE_CYC      = 2;
  localparam int RD_ROWS        = 2;
  localparam int RD_CYC_PER_ROW = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_RD1_A,
    ST_RD1_B,
    ST_RD2_A,
    ST_RD2_B
  } cap_state_t;

  function automatic int unsigned clamp_ex(input int unsigned v,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/ctrl_phase_timer.sv
// Loadable down-counter timing the ERASE and EXPOSE phases; o_last flags the final cycle.
module ctrl_phase_timer #(
  parameter int EX_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [EX_W-1:0] i_load_val,
  output logic            o_last
);

  logic [EX_W-1:0] r_count;

  // Parks at zero once drained so it can never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == EX_W'(1));

endmodule

// File: rtl/ctrl_capture_seq.sv
// Capture sequencer: erase / expose / two-row readout for the pixel array.
// All outputs are registered and depend on the state only.
module ctrl_capture_seq
  import cam_pkg::*;
#(
  parameter int EX_W_P      = EX_W,
  parameter int EX_MIN_P    = EX_MIN,
  parameter int EX_MAX_P    = EX_MAX,
  parameter int ERASE_CYC_P = ERASE_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic              i_exposure,
  input  logic [EX_W_P-1:0] i_ex_time,
  output logic              o_erase,
  output logic              o_expose,
  output logic              o_nre_1,
  output logic              o_nre_2,
  output logic              o_adc,
  output logic              o_busy,
  output logic              o_done
);

  cap_state_t        r_state;
  logic              r_erase;
  logic              r_expose;
  logic              r_nre_1;
  logic              r_nre_2;
  logic              r_adc;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_last;
  logic [EX_W_P-1:0] w_ex_clamped;
  logic [EX_W_P-1:0] w_load_val;

  assign w_ex_clamped = EX_W_P'(clamp_ex(32'(i_ex_time), EX_MIN_P, EX_MAX_P));
  // The timer load doubles as the exposure latch: later ex_time changes are not seen.
  assign w_load       = (r_state == ST_IDLE) && (i_init || i_exposure);
  assign w_load_val   = i_init ? EX_W_P'(ERASE_CYC_P) : w_ex_clamped;

  ctrl_phase_timer #(
    .EX_W (EX_W_P)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_last     (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_erase  <= 1'b0;
      r_expose <= 1'b0;
      r_nre_1  <= 1'b1;
      r_nre_2  <= 1'b1;
      r_adc    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_erase  <= 1'b0;
      r_expose <= 1'b0;
      r_nre_1  <= 1'b1;
      r_nre_2  <= 1'b1;
      r_adc    <= 1'b0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_init) begin
            r_state <= ST_ERASE;
            r_erase <= 1'b1;
          end else if (i_exposure) begin
            r_state  <= ST_EXPOSE;
            r_expose <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_ERASE: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_erase <= 1'b1;
          end
        end
        ST_EXPOSE: begin
          if (w_last) begin
            r_state <= ST_RD1_A;
            r_nre_1 <= 1'b0;
          end else begin
            r_expose <= 1'b1;
          end
        end
        ST_RD1_A: begin
          r_state <= ST_RD1_B;
          r_nre_1 <= 1'b0;
          r_adc   <= 1'b1;
        end
        ST_RD1_B: begin
          r_state <= ST_RD2_A;
          r_nre_2 <= 1'b0;
        end
        ST_RD2_A: begin
          r_state <= ST_RD2_B;
          r_nre_2 <= 1'b0;
          r_adc   <= 1'b1;
        end
        ST_RD2_B: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_erase  = r_erase;
  assign o_expose = r_expose;
  assign o_nre_1  = r_nre_1;
  assign o_nre_2  = r_nre_2;
  assign o_adc    = r_adc;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_ctrl_capture_seq.sv
// Scoreboard bench for ctrl_capture_seq: a schedule-based reference model predicts
// the output vector of every cycle; a negedge monitor pops and compares.
module tb_ctrl_capture_seq;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       init     = 1'b0;
  logic       exposure = 1'b0;
  logic [4:0] ex_time  = 5'd0;
  logic       o_erase, o_expose, o_nre_1, o_nre_2, o_adc, o_busy, o_done;

  int total = 0;
  int bad   = 0;

  // Vector layout: {erase, expose, nre_1, nre_2, adc, busy, done}
  localparam logic [6:0] V_IDLE  = 7'b0011000;
  localparam logic [6:0] V_ERASE = 7'b1011010;
  localparam logic [6:0] V_EXP   = 7'b0111010;
  localparam logic [6:0] V_R1A   = 7'b0001010;
  localparam logic [6:0] V_R1B   = 7'b0001110;
  localparam logic [6:0] V_R2A   = 7'b0010010;
  localparam logic [6:0] V_R2B   = 7'b0010110;
  localparam logic [6:0] V_DONE  = 7'b0011001;

  logic [6:0] sched[$];
  logic [6:0] exp_q[$];
  bit         prev_busy = 1'b0;

  ctrl_capture_seq dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_init     (init),
    .i_exposure (exposure),
    .i_ex_time  (ex_time),
    .o_erase    (o_erase),
    .o_expose   (o_expose),
    .o_nre_1    (o_nre_1),
    .o_nre_2    (o_nre_2),
    .o_adc      (o_adc),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  // Reference model: on an accepted trigger, the whole phase timeline is queued at once.
  always @(posedge clk) begin
    logic [6:0] v;
    int n;
    if (!rst_n) begin
      sched.delete();
      prev_busy = 1'b0;
      exp_q.push_back(V_IDLE);
    end else begin
      if (!prev_busy) begin
        if (init) begin
          repeat (2) sched.push_back(V_ERASE);
          $display("txn erase   t=%0t", $time);
        end else if (exposure) begin
          n = int'(ex_time);
          if (n < 2)  n = 2;
          if (n > 30) n = 30;
          repeat (n) sched.push_back(V_EXP);
          sched.push_back(V_R1A);
          sched.push_back(V_R1B);
          sched.push_back(V_R2A);
          sched.push_back(V_R2B);
          sched.push_back(V_DONE);
          $display("txn capture t=%0t ex_time=%0d n=%0d", $time, ex_time, n);
        end
      end
      v = (sched.size() != 0) ? sched.pop_front() : V_IDLE;
      prev_busy = v[1];
      exp_q.push_back(v);
    end
  end

  always @(negedge rst_n) begin
    sched.delete();
    prev_busy = 1'b0;
  end

  // Monitor
  always @(negedge clk) begin
    logic [6:0] act;
    logic [6:0] want;
    bit         have;
    act  = {o_erase, o_expose, o_nre_1, o_nre_2, o_adc, o_busy, o_done};
    have = 1'b0;
    want = V_IDLE;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      have = 1'b1;
    end
    if (!rst_n) begin
      want = V_IDLE;
      have = 1'b1;
    end
    if (have) begin
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL outputs t=%0t actual=%b required=%b (erase,expose,nre1,nre2,adc,busy,done)",
                 $time, act, want);
      end
    end
    total++;
    if (!o_nre_1 && !o_nre_2) begin
      bad++;
      $display("FAIL row_overlap t=%0t nre_1=%b nre_2=%b required not both low", $time, o_nre_1, o_nre_2);
    end
    total++;
    if ($countones({o_erase, o_expose, o_adc}) > 1) begin
      bad++;
      $display("FAIL phase_onehot t=%0t erase/expose/adc=%b required at most one high",
               $time, {o_erase, o_expose, o_adc});
    end
  end

  task automatic step(input bit ii, input bit ee, input logic [4:0] tt, input int n);
    init     = ii;
    exposure = ee;
    ex_time  = tt;
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    int r;
    bit ri, re;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    step(1'b0, 1'b1, 5'd15, 1);
    step(1'b0, 1'b0, 5'd15, 25);

    step(1'b0, 1'b1, 5'd0, 1);
    step(1'b0, 1'b0, 5'd0, 8);
    step(1'b0, 1'b1, 5'd31, 1);
    step(1'b0, 1'b0, 5'd31, 38);

    step(1'b1, 1'b1, 5'd9, 1);
    step(1'b0, 1'b0, 5'd9, 6);

    step(1'b0, 1'b1, 5'd10, 1);
    step(1'b0, 1'b0, 5'd10, 3);
    step(1'b0, 1'b1, 5'd3, 2);
    step(1'b0, 1'b0, 5'd3, 20);

    step(1'b0, 1'b1, 5'd20, 1);
    step(1'b0, 1'b0, 5'd20, 4);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 5'd20, 2);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 5'd7, 1);
    step(1'b0, 1'b0, 5'd7, 15);

    step(1'b0, 1'b1, 5'd2, 30);
    step(1'b0, 1'b0, 5'd2, 8);

    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      ri = (r < 5);
      re = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step(ri, re, 5'($urandom), 1);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 5'd0, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
